// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one W-bit add/sub/mul/div ALU.
// Define ALU_DIV_EN to build the W-cycle restoring divider; otherwise div reports err.
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [W*NREQ-1:0]       req_x,
    input  logic [W*NREQ-1:0]       req_y,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_result,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] cand;
    logic [NREQ-1:0] gnt;
    logic          found;
    logic          accept;

    logic [IW-1:0] op_id;
    logic [1:0]    op_q;
    logic [W-1:0]  op_x;
    logic [W-1:0]  op_y;

    logic          exec_done;
    logic [W-1:0]  exec_res;
    logic          exec_err;

`ifdef ALU_DIV_EN
    localparam int CW = $clog2(W);

    logic [W-1:0]  div_rem;
    logic [W-1:0]  div_rem_nx;
    logic [W-1:0]  div_q_nx;
    logic [W:0]    div_sh;
    logic          div_ge;
    logic [CW-1:0] div_cnt;

    // One restoring-division step; op_x doubles as the quotient shift register
    always_comb begin
        div_sh     = {div_rem, op_x[W-1]};
        div_ge     = div_sh >= {1'b0, op_y};
        div_rem_nx = div_ge ? (div_sh[W-1:0] - op_y) : div_sh[W-1:0];
        div_q_nx   = {op_x[W-2:0], div_ge};
    end
`endif

    // Rotating priority search starting just after the last granted requester
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign accept    = |req_ready;
    assign busy      = (state != IDLE);

    // Result of the current EXEC cycle and whether the op finishes on it
    always_comb begin
        exec_done = 1'b1;
        exec_res  = '0;
        exec_err  = 1'b0;
        unique case (op_q)
            2'b00: exec_res = op_x + op_y;
            2'b01: exec_res = op_x - op_y;
            2'b10: exec_res = op_x * op_y;
            default: begin
`ifdef ALU_DIV_EN
                if (op_y == '0) begin
                    exec_res = '1;
                    exec_err = 1'b1;
                end else begin
                    exec_done = (div_cnt == CW'(W - 1));
                    exec_res  = div_q_nx;
                end
`else
                exec_err = 1'b1;
`endif
            end
        endcase
    end

    // Scheduler FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            op_id      <= '0;
            op_q       <= '0;
            op_x       <= '0;
            op_y       <= '0;
`ifdef ALU_DIV_EN
            div_rem    <= '0;
            div_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        state      <= EXEC;
                        last_grant <= gnt_id;
                        op_id      <= gnt_id;
                        op_q       <= req_op[2*gnt_id +: 2];
                        op_x       <= req_x[W*gnt_id +: W];
                        op_y       <= req_y[W*gnt_id +: W];
`ifdef ALU_DIV_EN
                        div_rem    <= '0;
                        div_cnt    <= '0;
`endif
                    end
                end
                EXEC: begin
`ifdef ALU_DIV_EN
                    if (op_q == 2'b11) begin
                        div_rem <= div_rem_nx;
                        op_x    <= div_q_nx;
                        div_cnt <= div_cnt + CW'(1);
                    end
`endif
                    if (exec_done) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= op_id;
                        rsp_result <= exec_res;
                        rsp_err    <= exec_err;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed and random checks against a transaction-level model.
// Honours ALU_DIV_EN the same way as the design.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IW   = $clog2(NREQ);
    localparam int MOD  = 1 << W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_op = '0;
    logic [W*NREQ-1:0]   req_x = '0;
    logic [W*NREQ-1:0]   req_y = '0;
    logic                rsp_valid;
    logic [IW-1:0]       rsp_id;
    logic [W-1:0]        rsp_result;
    logic                rsp_err;
    logic                busy;

    alu_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: cycle index, accept/response cycles, pending and held response
    int cyc = 0;
    int m_acc = -1;
    int m_done = -1;
    int m_last = NREQ - 1;
    int p_id, p_res;
    int p_err;
    int o_id = 0, o_res = 0;
    int o_err = 0;
    int gq[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W*NREQ-1:0] rep(input logic [W-1:0] a);
        return {NREQ{a}};
    endfunction

    // apply one cycle of inputs, compare all outputs with the model, advance
    task automatic step(input logic [NREQ-1:0] v, input logic [2*NREQ-1:0] o,
                        input logic [W*NREQ-1:0] x, input logic [W*NREQ-1:0] y);
        logic [NREQ-1:0] exp_ready;
        int g, xi, yi, lat;
        bit exp_rv, exp_busy;
        req_valid = v;
        req_op    = o;
        req_x     = x;
        req_y     = y;
        #1;
        exp_rv   = (cyc == m_done);
        exp_busy = (cyc > m_acc) && (cyc <= m_done);
        if (exp_rv) begin
            o_id  = p_id;
            o_res = p_res;
            o_err = p_err;
        end
        exp_ready = '0;
        if (cyc > m_done) begin
            g = pick(v, m_last);
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                xi  = int'(x[W*g +: W]);
                yi  = int'(y[W*g +: W]);
                lat = 2;
                p_id  = g;
                p_err = 0;
                case (o[2*g +: 2])
                    2'b00: p_res = (xi + yi) % MOD;
                    2'b01: p_res = (xi - yi + MOD) % MOD;
                    2'b10: p_res = (xi * yi) % MOD;
                    default: begin
`ifdef ALU_DIV_EN
                        if (yi == 0) begin
                            p_res = MOD - 1;
                            p_err = 1;
                        end else begin
                            p_res = xi / yi;
                            lat   = W + 1;
                        end
`else
                        p_res = 0;
                        p_err = 1;
`endif
                    end
                endcase
                m_acc  = cyc;
                m_done = cyc + lat;
                m_last = g;
            end
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gq.push_back(i);
        check("ready", req_ready, exp_ready);
        check("busy", busy, exp_busy);
        check("rsp_valid", rsp_valid, exp_rv);
        check("rsp_id", rsp_id, o_id);
        check("rsp_result", rsp_result, o_res);
        check("rsp_err", rsp_err, o_err);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    // one reset cycle, then check every reset value and restart the model
    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        m_acc  = cyc - 1;
        m_done = cyc - 1;
        m_last = NREQ - 1;
        o_id   = 0;
        o_res  = 0;
        o_err  = 0;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_result", rsp_result, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);
    endtask

    logic [NREQ-1:0]   rv;
    logic [2*NREQ-1:0] ro;
    logic [W*NREQ-1:0] rx, ry;

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // 1: add wraps, response two cycles after accept
        step(4'b0001, '0, rep(8'd200), rep(8'd100));
        step('0, '0, '0, '0);
        check("t1_valid", rsp_valid, 1);
        check("t1_id", rsp_id, 0);
        check("t1_result", rsp_result, 44);
        check("t1_err", rsp_err, 0);
        idle_steps(1);

        // 2: all requesters hold sub, grants rotate 0,1,2,3,0
        do_reset();
        gq.delete();
        for (int i = 0; i < 15; i++) step(4'b1111, {NREQ{2'b01}}, rep(8'd50), rep(8'd7));
        check("t2_ngrants", gq.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            check("t2_grant", (k < gq.size()) ? gq[k] : -1, k % NREQ);
        idle_steps(3);

        // 3: divide and divide-by-zero
        do_reset();
        step(4'b0001, {NREQ{2'b11}}, rep(8'd200), rep(8'd7));
`ifdef ALU_DIV_EN
        idle_steps(W);
        check("t3_valid", rsp_valid, 1);
        check("t3_result", rsp_result, 28);
        check("t3_err", rsp_err, 0);
`else
        idle_steps(1);
        check("t3_valid", rsp_valid, 1);
        check("t3_result", rsp_result, 0);
        check("t3_err", rsp_err, 1);
`endif
        idle_steps(1);
        step(4'b0010, {NREQ{2'b11}}, rep(8'd9), rep(8'd0));
        idle_steps(1);
        check("t3z_valid", rsp_valid, 1);
        check("t3z_id", rsp_id, 1);
`ifdef ALU_DIV_EN
        check("t3z_result", rsp_result, 8'hFF);
`else
        check("t3z_result", rsp_result, 0);
`endif
        check("t3z_err", rsp_err, 1);
        idle_steps(1);

        // 4: mul keeps low bits; div x=9 y=3
        step(4'b0100, {NREQ{2'b10}}, rep(8'd20), rep(8'd13));
        idle_steps(1);
        check("t4_result", rsp_result, 4);
        check("t4_id", rsp_id, 2);
        idle_steps(1);
        step(4'b1000, {NREQ{2'b11}}, rep(8'd9), rep(8'd3));
`ifdef ALU_DIV_EN
        idle_steps(W);
        check("t4d_result", rsp_result, 3);
        check("t4d_err", rsp_err, 0);
`else
        idle_steps(1);
        check("t4d_result", rsp_result, 0);
        check("t4d_err", rsp_err, 1);
`endif
        idle_steps(1);

        // 5: reset in the middle of a divide aborts it
        do_reset();
        step(4'b0100, {NREQ{2'b11}}, rep(8'd200), rep(8'd7));
        idle_steps(3);
        do_reset();
        req_valid = 4'b1111;
        #1;
        check("t5_ready", req_ready, 4'b0001);
        step(4'b1111, '0, rep(8'd1), rep(8'd2));
        idle_steps(W + 2);

        // 6: req 2 arriving during req 1 service beats req 0
        do_reset();
        step(4'b0011, '0, rep(8'd3), rep(8'd4));
        idle_steps(2);
        step(4'b0010, '0, rep(8'd3), rep(8'd4));
        step(4'b0101, '0, rep(8'd3), rep(8'd4));
        step(4'b0101, '0, rep(8'd3), rep(8'd4));
        req_valid = 4'b0101;
        #1;
        check("t6_ready", req_ready, 4'b0100);
        step(4'b0101, '0, rep(8'd3), rep(8'd4));
        idle_steps(3);

        // random traffic with sticky valids, zero divisors and rare resets
        rv = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) rv[i] = ~rv[i];
                ro[2*i +: 2] = 2'($urandom_range(0, 3));
                rx[W*i +: W] = W'($urandom);
                ry[W*i +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            end
            step(rv, ro, rx, ry);
        end
        idle_steps(W + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
